// File: rtl/inv_lane_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inv_lane_arbiter_pkg
//  Description : Shared FSM state and operation encodings for the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package inv_lane_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_PASS = 1'b0;
    localparam logic OP_INV  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/inv_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : inv_rr_pick
//  Description : Combinational round-robin picker; searches upward from
//                last_grant+1 with wrap. Lock hint honoured when
//                INV_ARB_LOCK_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module inv_rr_pick
    import inv_lane_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IDW-1:0]   i_last_grant,
`ifdef INV_ARB_LOCK_EN
    input  logic             i_lock_hint,
`endif
    output logic [IDW-1:0]   o_grant,
    output logic             o_any_valid
);

    logic [IDW-1:0] w_pos;

    always_comb begin
        o_grant     = '0;
        o_any_valid = 1'b0;
        w_pos       = '0;
        // Walk from farthest to nearest so the nearest valid index wins.
        for (int k = N_REQ; k >= 1; k--) begin
            w_pos = IDW'((int'(i_last_grant) + k) % N_REQ);
            if (i_valid[w_pos]) begin
                o_grant     = w_pos;
                o_any_valid = 1'b1;
            end
        end
`ifdef INV_ARB_LOCK_EN
        if (i_lock_hint && i_valid[i_last_grant]) begin
            o_grant = i_last_grant;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/inv_lane_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : inv_lane_arbiter
//  Description : Round-robin arbiter sharing one registered invert/pass lane
//                among N_REQ requesters (accept -> exec -> respond).
//                Optional feature macro: INV_ARB_LOCK_EN (adds req_lock).
//  Revision    : 1.0  initial release
// ============================================================================
module inv_lane_arbiter
    import inv_lane_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_op,
`ifdef INV_ARB_LOCK_EN
    input  logic [N_REQ-1:0]    req_lock,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DW-1:0]       rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_last_grant;
    logic [IDW-1:0] r_grant;
    logic [IDW-1:0] w_pick;
    logic           w_any;
    logic           w_accept;
    logic [DW-1:0]  r_operand;
    logic [DW-1:0]  r_result;
    logic           r_op;
`ifdef INV_ARB_LOCK_EN
    logic           r_lock;
`endif

    inv_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .i_valid      (req_valid),
        .i_last_grant (r_last_grant),
`ifdef INV_ARB_LOCK_EN
        .i_lock_hint  (r_lock),
`endif
        .o_grant      (w_pick),
        .o_any_valid  (w_any)
    );

    // Accept is masked during reset so req_ready stays low while rst_n is low.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && rst_n) begin
                    w_accept          = 1'b1;
                    req_ready[w_pick] = 1'b1;
                    w_state_nxt       = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDW'(N_REQ - 1);
            r_grant      <= '0;
            r_operand    <= '0;
            r_op         <= OP_PASS;
            r_result     <= '0;
`ifdef INV_ARB_LOCK_EN
            r_lock       <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_grant   <= w_pick;
                r_operand <= req_data[w_pick*DW +: DW];
                r_op      <= req_op[w_pick];
`ifdef INV_ARB_LOCK_EN
                r_lock    <= req_lock[w_pick];
`endif
            end
            if (r_state == ST_EXEC) begin
                case (r_op)
                    OP_PASS: r_result <= r_operand;
                    default: r_result <= ~r_operand;
                endcase
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_result;
    assign rsp_id    = r_grant;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_inv_lane_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for inv_lane_arbiter with a response scoreboard.
module tb_inv_lane_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int IDW   = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_op;
`ifdef INV_ARB_LOCK_EN
    logic [N_REQ-1:0]    req_lock;
`endif
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DW-1:0]       rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic                busy;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_last = N_REQ - 1;
    bit   m_lock = 1'b0;

    always #5 clk = ~clk;

    inv_lane_arbiter #(
        .N_REQ (N_REQ),
        .DW    (DW),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_op    (req_op),
`ifdef INV_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    function automatic int model_pick(logic [N_REQ-1:0] v, int last, bit lock);
        if (lock && v[last]) return last;
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return 0;
    endfunction

    function automatic exp_t make_exp(int g);
        exp_t e;
        e.id   = IDW'(g);
        e.data = req_op[g] ? ~req_data[g*DW +: DW] : req_data[g*DW +: DW];
        return e;
    endfunction

    task automatic randomize_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            req_data[i*DW +: DW] = DW'($urandom);
            req_op[i]            = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
`ifdef INV_ARB_LOCK_EN
        req_lock  = '0;
`endif
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_last = N_REQ - 1;
        m_lock = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        int got_rsp = 0;
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_op    = '0;
        randomize_reqs();
`ifdef INV_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        sb.push_back(make_exp(0));
        @(posedge clk); #1;
        req_valid = '0;
        for (int cyc = 0; cyc < 8 && got_rsp == 0; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                exp_t e;
                got_rsp = 1;
                e = sb.pop_front();
                checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL reset_rsp_id_after: got %0d want %0d", rsp_id, e.id); end
                checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL reset_rsp_data_after: got %h want %h", rsp_data, e.data); end
                m_last = int'(e.id);
            end
            @(posedge clk); #1;
        end
        checks++; if (got_rsp == 0) begin errors++; $display("FAIL reset_rsp_timeout: got none want one response"); end
    endtask

    task automatic test_single();
        for (int pass = 0; pass < 2; pass++) begin
            int   acc_cyc = -1;
            int   rsp_cyc = -1;
            logic op;
            exp_t e;
            op = (pass == 0);
            @(posedge clk); #1;
            req_valid            = 4'b0100;
            req_data[2*DW +: DW] = 8'hA5;
            req_op[2]            = op;
            rsp_ready            = 1'b1;
            for (int cyc = 0; cyc < 12 && rsp_cyc < 0; cyc++) begin
                @(negedge clk);
                if (req_ready != '0 && acc_cyc < 0) begin
                    acc_cyc = cyc;
                    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
                    e.id   = 2'd2;
                    e.data = op ? 8'h5A : 8'hA5;
                    sb.push_back(e);
                end
                if (rsp_valid) begin
                    rsp_cyc = cyc;
                    e = sb.pop_front();
                    checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL single_data op=%0b: got %h want %h", op, rsp_data, e.data); end
                    checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL single_id: got %0d want %0d", rsp_id, e.id); end
                    checks++; if (rsp_cyc - acc_cyc != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", rsp_cyc - acc_cyc); end
                    m_last = 2;
                end
                @(posedge clk); #1;
                if (acc_cyc == cyc) req_valid = '0;
            end
            checks++; if (rsp_cyc < 0) begin errors++; $display("FAIL single_timeout: got no response want one"); end
        end
    endtask

    task automatic test_fairness();
        int n_acc = 0;
        int n_rsp = 0;
        do_reset();
        randomize_reqs();
        req_valid = '1;
        for (int cyc = 0; cyc < 60 && n_rsp < 8; cyc++) begin
            int               g = -1;
            int               eg;
            logic [N_REQ-1:0] want;
            exp_t             e;
            @(negedge clk);
            if (req_ready != '0) begin
                eg   = model_pick(req_valid, m_last, m_lock);
                want = '0;
                want[n_acc % N_REQ] = 1'b1;
                checks++; if (req_ready !== want) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", n_acc, req_ready, want); end
                sb.push_back(make_exp(eg));
                m_lock = 1'b0;
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
                n_acc++;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL fair_unexpected_rsp: got id %0d want none", rsp_id);
                end else begin
                    e = sb.pop_front();
                    checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL fair_rsp_id[%0d]: got %0d want %0d", n_rsp, rsp_id, e.id); end
                    checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL fair_rsp_data[%0d]: got %h want %h", n_rsp, rsp_data, e.data); end
                    m_last = int'(e.id);
                end
                n_rsp++;
            end
            @(posedge clk); #1;
            if (g >= 0) begin
                req_data[g*DW +: DW] = DW'($urandom);
                req_op[g]            = 1'($urandom_range(0, 1));
            end
        end
        checks++; if (n_rsp < 8) begin errors++; $display("FAIL fair_timeout: got %0d want 8 responses", n_rsp); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        m_last = (n_acc - 1) % N_REQ;
        sb.delete();
    endtask

    task automatic test_backpressure();
        int   seen = 0;
        int   eg;
        exp_t e;
        do_reset();
        randomize_reqs();
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                eg = model_pick(req_valid, m_last, m_lock);
                checks++; if (req_ready !== (4'b0001 << eg)) begin errors++; $display("FAIL bp_grant: got %b want %b", req_ready, 4'b0001 << eg); end
                sb.push_back(make_exp(eg));
            end
            if (rsp_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL bp_timeout: got no rsp_valid want one"); end
        e = sb[0];
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, rsp_valid); end
            checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want %h", k, rsp_data, e.data); end
            checks++; if (rsp_id !== e.id) begin errors++; $display("FAIL bp_hold_id[%0d]: got %0d want %0d", k, rsp_id, e.id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_ready[%0d]: got %b want 0000", k, req_ready); end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== e.data) begin errors++; $display("FAIL bp_release_data: got %b/%h want 1/%h", rsp_valid, rsp_data, e.data); end
        m_last = int'(e.id);
        @(posedge clk); #1;
        @(negedge clk);
        eg = model_pick(req_valid, m_last, m_lock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_after_release: got busy=%b want 0", busy); end
        checks++; if (req_ready !== (4'b0001 << eg)) begin errors++; $display("FAIL bp_next_grant: got %b want %b", req_ready, 4'b0001 << eg); end
        sb.push_back(make_exp(eg));
        @(posedge clk); #1;
        req_valid = '0;
        seen = 0;
        for (int cyc = 0; cyc < 8 && seen == 0; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                e = sb.pop_front();
                checks++; if (rsp_id !== e.id || rsp_data !== e.data) begin errors++; $display("FAIL bp_next_rsp: got %0d/%h want %0d/%h", rsp_id, rsp_data, e.id, e.data); end
                m_last = int'(e.id);
            end
            @(posedge clk); #1;
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL bp_next_timeout: got no response want one"); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_reset();
        randomize_reqs();
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_pre_grant: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        for (int cyc = 0; cyc < 8 && seen == 0; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL mid_pre_rsp_id: got %0d want 1", rsp_id); end
            end
            @(posedge clk); #1;
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL mid_pre_timeout: got no response want one"); end
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_in_exec: got busy=%b want 1", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last = N_REQ - 1;
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_dropped[%0d]: got valid=%b busy=%b want 0/0", k, rsp_valid, busy); end
            @(posedge clk); #1;
        end
        req_valid = '1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart_grant: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        m_last = 0;
    endtask

`ifdef INV_ARB_LOCK_EN
    task automatic test_lock();
        int seq[7] = '{0, 1, 1, 1, 2, 3, 0};
        int n_acc = 0;
        int n_rsp = 0;
        do_reset();
        randomize_reqs();
        req_valid = '1;
        req_lock  = 4'b0010;
        for (int cyc = 0; cyc < 60 && n_rsp < 7; cyc++) begin
            int               g = -1;
            int               eg;
            logic [N_REQ-1:0] want;
            exp_t             e;
            @(negedge clk);
            if (req_ready != '0) begin
                eg   = model_pick(req_valid, m_last, m_lock);
                want = '0;
                if (n_acc < 7) want[seq[n_acc]] = 1'b1;
                checks++; if (req_ready !== want) begin errors++; $display("FAIL lock_grant[%0d]: got %b want %b", n_acc, req_ready, want); end
                sb.push_back(make_exp(eg));
                m_lock = req_lock[eg];
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
                n_acc++;
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                checks++; if (rsp_id !== e.id || rsp_data !== e.data) begin errors++; $display("FAIL lock_rsp[%0d]: got %0d/%h want %0d/%h", n_rsp, rsp_id, rsp_data, e.id, e.data); end
                m_last = int'(e.id);
                n_rsp++;
            end
            @(posedge clk); #1;
            if (g >= 0) begin
                req_data[g*DW +: DW] = DW'($urandom);
                if (n_acc == 3) req_lock = '0;
            end
        end
        checks++; if (n_rsp < 7) begin errors++; $display("FAIL lock_timeout: got %0d want 7 responses", n_rsp); end
        req_valid = '0;
        repeat (3) @(posedge clk);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
`ifdef INV_ARB_LOCK_EN
        req_lock  = '0;
`endif
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef INV_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
